// File: rtl/image_pkg.sv
// Shared image-pipeline definitions: default widths and the delay_sel clamp.
package image_pkg;

  localparam int DEFAULT_N         = 8;
  localparam int DEFAULT_CH        = 1;
  localparam int DEFAULT_MAX_DELAY = 16;

  // A request of 0 means "one register"; anything beyond the buffer saturates.
  function automatic int clamp_delay(input int sel, input int max_delay);
    if (sel <= 0) return 1;
    if (sel > max_delay) return max_delay;
    return sel;
  endfunction

endpackage

// File: rtl/delay_line_ram.sv
// Circular storage for delay_line: synchronous write, registered read and
// a resettable valid bit per entry. Data bits are never reset.
module delay_line_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic          i_flush,
  input  logic [PW-1:0] i_waddr,
  input  logic          i_wvalid,
  input  logic [W-1:0]  i_wdata,
  input  logic [PW-1:0] i_raddr,
  output logic          o_rvalid,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic             r_rvalid;
  logic [W-1:0]     r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // The write is placed after the flush clear so a same-edge write survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld    <= '0;
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (i_we) begin
        r_rvalid <= r_vld[i_raddr];
        r_rdata  <= r_mem[i_raddr];
      end
      if (i_flush) begin
        r_vld    <= '0;
        r_rvalid <= 1'b0;
      end
      if (i_we) r_vld[i_waddr] <= i_wvalid;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;

endmodule

// File: rtl/delay_line.sv
// Runtime-programmable multi-channel delay line over a circular buffer.
// Optional flush input is enabled by defining DELAY_LINE_FLUSH_EN.
module delay_line
  import image_pkg::*;
#(
  parameter  int N         = DEFAULT_N,
  parameter  int CH        = DEFAULT_CH,
  parameter  int MAX_DELAY = DEFAULT_MAX_DELAY,
  localparam int AW        = $clog2(MAX_DELAY + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
`ifdef DELAY_LINE_FLUSH_EN
  input  logic            flush,
`endif
  input  logic [AW-1:0]   delay_sel,
  input  logic            in_valid,
  input  logic [CH*N-1:0] in,
  output logic            out_valid,
  output logic [CH*N-1:0] out,
  output logic            primed
);

  localparam int PW = $clog2(MAX_DELAY);
  localparam int W  = CH * N;

  logic [PW-1:0] r_wp;
  logic [AW-1:0] r_fill_cnt;
  logic          r_primed;
  logic [AW-1:0] r_sel_prev;
  logic          r_byp_sel;
  logic          r_byp_valid;
  logic [W-1:0]  r_byp_data;

  logic          w_flush;
  logic [AW-1:0] w_deff;
  logic [PW-1:0] w_raddr;
  logic [PW-1:0] w_wp_next;
  logic [AW-1:0] w_fill_next;
  logic          w_sel_chg;
  logic          w_ram_valid;
  logic [W-1:0]  w_ram_data;

`ifdef DELAY_LINE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_deff      = AW'(clamp_delay(int'(delay_sel), MAX_DELAY));
  assign w_wp_next   = (r_wp == PW'(MAX_DELAY - 1)) ? '0 : r_wp + 1'b1;
  assign w_fill_next = (r_fill_cnt < w_deff) ? r_fill_cnt + 1'b1 : r_fill_cnt;
  assign w_sel_chg   = (delay_sel != r_sel_prev);

  // Read address is wp-(Deff-1) modulo the buffer depth.
  always_comb begin
    int t;
    t = int'(r_wp) + MAX_DELAY - (int'(w_deff) - 1);
    if (t >= MAX_DELAY) t = t - MAX_DELAY;
    w_raddr = PW'(t);
  end

  delay_line_ram #(.W(W), .DEPTH(MAX_DELAY), .PW(PW)) u_ram (
    .clk      (clk),
    .rst      (rst),
    .i_we     (ce),
    .i_flush  (w_flush),
    .i_waddr  (r_wp),
    .i_wvalid (in_valid),
    .i_wdata  (in),
    .i_raddr  (w_raddr),
    .o_rvalid (w_ram_valid),
    .o_rdata  (w_ram_data)
  );

  // r_sel_prev follows delay_sel during reset so the first enabled edge is not a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp        <= '0;
      r_fill_cnt  <= '0;
      r_primed    <= 1'b0;
      r_sel_prev  <= delay_sel;
      r_byp_sel   <= 1'b0;
      r_byp_valid <= 1'b0;
      r_byp_data  <= '0;
    end else begin
      if (ce) begin
        r_wp        <= w_wp_next;
        r_sel_prev  <= delay_sel;
        r_byp_sel   <= (w_deff == AW'(1));
        r_byp_valid <= in_valid;
        r_byp_data  <= in;
      end
      if (w_flush) begin
        r_fill_cnt  <= '0;
        r_primed    <= 1'b0;
        r_byp_valid <= 1'b0;
      end else if (ce) begin
        if (w_sel_chg) begin
          r_fill_cnt <= '0;
          r_primed   <= 1'b0;
        end else begin
          r_fill_cnt <= w_fill_next;
          r_primed   <= (w_fill_next >= w_deff);
        end
      end
    end
  end

  assign out_valid = r_byp_sel ? r_byp_valid : w_ram_valid;
  assign out       = r_byp_sel ? r_byp_data  : w_ram_data;
  assign primed    = r_primed;

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line with N=8, CH=2, MAX_DELAY=16.
module tb_delay_line;

  localparam int N  = 8;
  localparam int CH = 2;
  localparam int MD = 16;
  localparam int AW = $clog2(MD + 1);

  logic            clk;
  logic            rst;
  logic            ce;
  logic [AW-1:0]   delay_sel;
  logic            in_valid;
  logic [CH*N-1:0] din;
  logic            out_valid;
  logic [CH*N-1:0] dout;
  logic            primed;
`ifdef DELAY_LINE_FLUSH_EN
  logic            flush;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  delay_line #(.N(N), .CH(CH), .MAX_DELAY(MD)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
`ifdef DELAY_LINE_FLUSH_EN
    .flush     (flush),
`endif
    .delay_sel (delay_sel),
    .in_valid  (in_valid),
    .in        (din),
    .out_valid (out_valid),
    .out       (dout),
    .primed    (primed)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Channel 1 carries a different value than channel 0 to expose skew.
  function automatic logic [15:0] mk(input int k);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = 8'(k);
    hi = 8'(k + 128);
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  int k;
  int e;
  int vp[10];

  initial begin
    rst = 1'b1; ce = 1'b0; in_valid = 1'b0; din = '0; delay_sel = AW'(5);
`ifdef DELAY_LINE_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("reset_out", 32'(dout), 32'(0));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_primed", 32'(primed), 32'(0));

    // Deff=5 ramp: sample 1 emerges after the 5th edge
    ce = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      din = mk(i);
      tick();
      chk("d5_valid", 32'(out_valid), 32'(i >= 5));
      chk("d5_primed", 32'(primed), 32'(i >= 5));
      if (i >= 5) chk("d5_data", 32'(dout), 32'(mk(i - 4)));
    end
    k = 20;

    // delay_sel=1 then delay_sel=0: both a one-register delay
    delay_sel = AW'(1);
    for (int i = 1; i <= 4; i++) begin
      k++; din = mk(k);
      tick();
      chk("d1_data", 32'(dout), 32'(mk(k)));
      chk("d1_valid", 32'(out_valid), 32'(1));
      chk("d1_primed", 32'(primed), 32'(i >= 2));
    end
    delay_sel = AW'(0);
    for (int i = 1; i <= 4; i++) begin
      k++; din = mk(k);
      tick();
      chk("d0_data", 32'(dout), 32'(mk(k)));
      chk("d0_valid", 32'(out_valid), 32'(1));
      chk("d0_primed", 32'(primed), 32'(i >= 2));
    end

    // delay_sel=20 clamps to 16; 50 edges wrap the buffer three times
    delay_sel = AW'(20);
    for (int i = 1; i <= 50; i++) begin
      k++; din = mk(k);
      tick();
      chk("d16_data", 32'(dout), 32'(mk(k - 15)));
      chk("d16_valid", 32'(out_valid), 32'(1));
      if (i == 1 || i == 16) chk("d16_primed_low", 32'(primed), 32'(0));
      if (i == 17) chk("d16_primed_high", 32'(primed), 32'(1));
    end

    // mid-stream reset with ce high: reset wins, stored valids cleared
    rst = 1'b1; delay_sel = AW'(3); din = mk(99);
    tick();
    rst = 1'b0;
    chk("midrst_out", 32'(dout), 32'(0));
    chk("midrst_valid", 32'(out_valid), 32'(0));
    chk("midrst_primed", 32'(primed), 32'(0));

    // ce toggling with Deff=3: latency counted in enabled edges
    e = 0;
    for (int i = 0; i < 8; i++) begin
      ce = (i % 2 == 0);
      if (ce) e++;
      din = ce ? mk(100 + e) : 16'hFFFF;
      tick();
      chk("ce_valid", 32'(out_valid), 32'(e >= 3));
      chk("ce_primed", 32'(primed), 32'(e >= 3));
      if (e >= 3) chk("ce_data", 32'(dout), 32'(mk(100 + e - 2)));
    end

    // in_valid pattern 1,0,1,1,0 with Deff=4 after a reset
    rst = 1'b1; ce = 1'b1; delay_sel = AW'(4); in_valid = 1'b1;
    tick();
    rst = 1'b0;
    vp = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 1; i <= 10; i++) begin
      in_valid = vp[i-1][0];
      din = mk(200 + i);
      tick();
      chk("pat_valid", 32'(out_valid), 32'((i >= 4) ? vp[i-4] : 0));
      if (i >= 4 && vp[i-4] == 1) chk("pat_data", 32'(dout), 32'(mk(200 + i - 3)));
    end

`ifdef DELAY_LINE_FLUSH_EN
    // flush at edge 10 with Deff=6
    rst = 1'b1; ce = 1'b1; delay_sel = AW'(6); in_valid = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      flush = (i == 10);
      din = mk(50 + i);
      tick();
      flush = 1'b0;
      chk("fl_valid", 32'(out_valid), 32'((i >= 6 && i <= 9) || i == 15));
      if ((i >= 6 && i <= 9) || i == 15) chk("fl_data", 32'(dout), 32'(mk(50 + i - 5)));
      if (i == 10) chk("fl_primed", 32'(primed), 32'(0));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
